// File: rtl/shared_mem_pkg.sv
// Shared types and sizing helpers for the shared-memory read arbiter.
package shared_mem_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic {
      CL_A = 1'b0,
      CL_B = 1'b1
   } client_t;

   localparam int DEF_N      = 4;
   localparam int DEF_ADDR_W = 4;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/shared_mem_rf.sv
// DEPTH x N 1R1W register file with a registered read port; the write port is
// shared between the init sweep and the client write path.
module shared_mem_rf
   import shared_mem_pkg::*;
#(
   parameter int          N        = DEF_N,
   parameter int          ADDR_W   = DEF_ADDR_W,
   parameter logic [N-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_init_active,
   input  logic [ADDR_W-1:0] i_init_addr,
   input  logic              i_cl_we,
   input  logic [ADDR_W-1:0] i_cl_addr,
   input  logic [N-1:0]      i_cl_data,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [N-1:0]      o_rdata
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [N-1:0]      r_mem [DEPTH];
   logic [N-1:0]      r_rdata;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [N-1:0]      w_wdata;

   // The sweep owns the write port outright while it runs.
   assign w_we    = i_init_active | i_cl_we;
   assign w_waddr = i_init_active ? i_init_addr : i_cl_addr;
   assign w_wdata = i_init_active ? INIT_VAL : i_cl_data;

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   // Read samples the array before this edge's write lands: old data on collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one register-file read port between clients A and B,
// with a post-reset sweep that clears the table before anyone is served.
//
//   state | meaning
//   INIT  | writing INIT_VAL to entry r_initPtr, all readies low
//   RUN   | write port open, one read grant per cycle by round robin
module shared_mem_arbiter
   import shared_mem_pkg::*;
#(
   parameter int           N        = DEF_N,
   parameter int           ADDR_W   = DEF_ADDR_W,
   parameter logic [N-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IN_rdA_valid,
   input  logic [ADDR_W-1:0] IN_rdA_addr,
   output logic              OUT_rdA_ready,
   output logic              OUT_rdA_rspValid,
   output logic [N-1:0]      OUT_rdA_data,
   input  logic              IN_rdB_valid,
   input  logic [ADDR_W-1:0] IN_rdB_addr,
   output logic              OUT_rdB_ready,
   output logic              OUT_rdB_rspValid,
   output logic [N-1:0]      OUT_rdB_data,
   input  logic              IN_wr_valid,
   input  logic [ADDR_W-1:0] IN_wr_addr,
   input  logic [N-1:0]      IN_wr_data,
   output logic              OUT_wr_ready,
   output logic              OUT_initDone
);

   localparam int DEPTH = depth_of(ADDR_W);
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

   state_t          r_state;
   logic [ADDR_W:0] r_initPtr;
   logic            r_initDone;
   client_t         r_rr;
   logic            r_rspA;
   logic            r_rspB;
   logic [N-1:0]    r_holdA;
   logic [N-1:0]    r_holdB;

   logic              w_run;
   logic              w_grantA;
   logic              w_grantB;
   logic [ADDR_W-1:0] w_raddr;
   logic [N-1:0]      w_rdata;

   assign w_run    = (r_state == RUN);
   assign w_grantA = w_run & IN_rdA_valid & (~IN_rdB_valid | (r_rr == CL_A));
   assign w_grantB = w_run & IN_rdB_valid & (~IN_rdA_valid | (r_rr == CL_B));
   assign w_raddr  = w_grantB ? IN_rdB_addr : IN_rdA_addr;

   shared_mem_rf #(
      .N        (N),
      .ADDR_W   (ADDR_W),
      .INIT_VAL (INIT_VAL)
   ) u_rf (
      .clk           (clk),
      .rst           (rst),
      .i_init_active (~w_run),
      .i_init_addr   (r_initPtr[ADDR_W-1:0]),
      .i_cl_we       (w_run & IN_wr_valid),
      .i_cl_addr     (IN_wr_addr),
      .i_cl_data     (IN_wr_data),
      .i_re          (w_grantA | w_grantB),
      .i_raddr       (w_raddr),
      .o_rdata       (w_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= INIT;
         r_initPtr  <= '0;
         r_initDone <= 1'b0;
         r_rr       <= CL_A;
         r_rspA     <= 1'b0;
         r_rspB     <= 1'b0;
         r_holdA    <= '0;
         r_holdB    <= '0;
      end else begin
         r_rspA <= w_grantA;
         r_rspB <= w_grantB;
         // Capture the delivered word so each client's data holds between pulses.
         if (r_rspA) begin
            r_holdA <= w_rdata;
         end
         if (r_rspB) begin
            r_holdB <= w_rdata;
         end
         case (r_state)
            INIT: begin
               r_initPtr <= r_initPtr + 1'b1;
               if (r_initPtr == LAST_PTR) begin
                  r_state    <= RUN;
                  r_initDone <= 1'b1;
               end
            end
            RUN: begin
               if (w_grantA) begin
                  r_rr <= CL_B;
               end else if (w_grantB) begin
                  r_rr <= CL_A;
               end
            end
            default: r_state <= INIT;
         endcase
      end
   end

   assign OUT_rdA_ready    = w_grantA;
   assign OUT_rdB_ready    = w_grantB;
   assign OUT_wr_ready     = w_run;
   assign OUT_initDone     = r_initDone;
   assign OUT_rdA_rspValid = r_rspA;
   assign OUT_rdB_rspValid = r_rspB;
   assign OUT_rdA_data     = r_rspA ? w_rdata : r_holdA;
   assign OUT_rdB_data     = r_rspB ? w_rdata : r_holdB;

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Wraps a DEPTH x N 1R1W register-file memory and shares its single read port between two read clients (A, B) using round-robin arbitration.
- One write client owns the write port.
- After reset, an init sequencer clears every entry before any client is served.
- Sits between the two lookup pipelines and the table-update path.

Parameters:
N, 4, data width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W (16)
INIT_VAL, 0, N-bit value written to every entry during init

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
IN_rdA_valid  input  1  client A read request
IN_rdA_addr  input  ADDR_W  client A read address
OUT_rdA_ready  output  1  client A request accepted this cycle
OUT_rdA_rspValid  output  1  client A read data valid
OUT_rdA_data  output  N  client A read data
IN_rdB_valid  input  1  client B read request
IN_rdB_addr  input  ADDR_W  client B read address
OUT_rdB_ready  output  1  client B request accepted this cycle
OUT_rdB_rspValid  output  1  client B read data valid
OUT_rdB_data  output  N  client B read data
IN_wr_valid  input  1  write request
IN_wr_addr  input  ADDR_W  write address
IN_wr_data  input  N  write data
OUT_wr_ready  output  1  write accepted this cycle
OUT_initDone  output  1  init sweep complete, clients may be served

Behaviour:
- Reset (async, active-high), all values below hold while rst is high:
  - state=INIT, initPtr=0, rr=0 (A preferred).
  - rspValid A/B = 0; data A/B = 0; OUT_initDone = 0.
  - Memory contents are undefined until the sweep completes.
- FSM state INIT:
  - Each cycle writes INIT_VAL to mem[initPtr], then initPtr+1.
  - All ready outputs = 0.
  - After writing entry DEPTH-1, go to RUN. This takes exactly DEPTH cycles after reset deassert.
  - OUT_initDone = 1 from the first RUN cycle onward.
- FSM state RUN, write path:
  - OUT_wr_ready = 1 (combinational).
  - Write commits at the clock edge when IN_wr_valid.
- FSM state RUN, read arbitration (combinational ready, one grant per cycle):
  - Only one client valid: grant it.
  - Both valid: grant rr (0=A, 1=B).
  - After any grant, rr <= the non-granted client. It holds if there is no grant.
  - Ready is asserted only to the granted client. Ready does not depend on wr_valid.
- Read latency: 1 cycle.
  - Edge following the grant: rspValid of the granted client = 1 and data = mem[addr].
  - The other client's rspValid = 0.
  - rspValid is a single-cycle pulse. Data holds its last value when rspValid = 0.
- Read/write same address, same cycle: the read returns the OLD contents. There is no forwarding.
- A client must hold valid/addr stable until ready. The arbiter does not sample an address while ready = 0.
- No backpressure on responses: clients must always accept rspValid.
- Address wrap: initPtr is ADDR_W+1 bits so termination does not alias. Client addresses are full-range; there is no out-of-range case.
- Reset mid-RUN: any in-flight response is dropped (rspValid 0), and the block re-runs the full init sweep.
- Reset mid-INIT: the sweep restarts from 0.

Decomposition:
- Package shared_mem_pkg holds:
  - typedef state_t {INIT, RUN}
  - client id enum {CL_A, CL_B}
  - localparam for DEPTH derivation
- Sub-module shared_mem_rf holds the storage: 1R1W, registered read, write port muxed between the init sequencer and the client.
- The arbiter and FSM live in the top module.

Test Plan:
- Reset release, no requests -> ready outputs 0 for 16 cycles, OUT_initDone rises on cycle 16. Reads of addr 0..15 then return 0.
- Write sequence, then reads:
  - Write addr 3 = 4'hA. Next cycle A reads addr 3 -> rdA_ready=1, rdA_rspValid=1 one cycle later with data 4'hA. rdB_rspValid stays 0.
- Fairness:
  - A and B both valid continuously (addr 1, addr 2, preloaded 4'h1/4'h2) -> grants alternate A,B,A,B.
  - Response data alternates 1,2.
  - Neither client waits more than 1 cycle.
- Single requester:
  - Only B valid for 3 cycles -> B granted every cycle.
  - Then A and B both valid -> A granted first (rr points to A).
- Read/write collision:
  - mem[5]=4'h3. Same cycle: write addr 5 = 4'hC and A reads addr 5 -> response 4'h3.
  - Read of addr 5 on the next cycle -> 4'hC.
- Reset mid-operation:
  - Assert rst in the cycle after a grant -> rspValid never pulses.
  - After release, 16 init cycles run and previously written data is cleared to 0.
